// File: rtl/mult4_pkg.sv
// +--------------------------------------------------------------------+
// | mult4_pkg : shared types and pin map for the 4x4 multiplier core    |
// | Revision  : 1.0                                                     |
// +--------------------------------------------------------------------+
`default_nettype none

package mult4_pkg;

  localparam int W = 4;

  localparam int START_BIT  = 0;
  localparam int SIGNED_BIT = 1;
  localparam int BUSY_BIT   = 2;
  localparam int DONE_BIT   = 3;

  localparam logic [7:0] UIO_OE_VAL = 8'h0C;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : mult4_pkg

`default_nettype wire

// File: rtl/mult4_datapath.sv
// +--------------------------------------------------------------------+
// | mult4_datapath : magnitude/sign split, shift-add accumulate, negate |
// | Revision       : 1.0                                                |
// +--------------------------------------------------------------------+
`default_nettype none

module mult4_datapath #(
  parameter int W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             signed_mode,
  input  logic [W-1:0]     a_in,
  input  logic [W-1:0]     b_in,
  output logic             last,
  output logic [2*W-1:0]   product
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]   mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic           neg_q, neg_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [CW-1:0]  count_q, count_d;
  logic [2*W-1:0] product_q, product_d;

  logic           a_neg, b_neg;
  logic [2*W-1:0] addend;

  assign last    = (count_q == CW'(W - 1));
  assign product = product_q;

  always_comb begin
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    neg_d     = neg_q;
    acc_d     = acc_q;
    count_d   = count_q;
    product_d = product_q;
    a_neg     = signed_mode & a_in[W-1];
    b_neg     = signed_mode & b_in[W-1];
    addend    = '0;

    if (load) begin
      // Magnitudes stay unsigned so that |-2^(W-1)| is representable.
      mcand_d  = a_neg ? (~a_in + 1'b1) : a_in;
      mplier_d = b_neg ? (~b_in + 1'b1) : b_in;
      neg_d    = a_neg ^ b_neg;
      acc_d    = '0;
      count_d  = '0;
    end else if (step) begin
      if (mplier_q[count_q]) begin
        addend = {{W{1'b0}}, mcand_q} << count_q;
      end
      acc_d   = acc_q + addend;
      count_d = count_q + 1'b1;
      if (last) begin
        product_d = neg_q ? (~acc_d + 1'b1) : acc_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      neg_q     <= 1'b0;
      acc_q     <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      neg_q     <= neg_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

endmodule : mult4_datapath

`default_nettype wire

// File: rtl/mult4_complete.sv
// +--------------------------------------------------------------------+
// | mult4_complete : sequential 4x4 multiplier behind Tiny Tapeout pins |
// | Revision       : 1.0                                                |
// +--------------------------------------------------------------------+
`default_nettype none

module mult4_complete #(
  parameter int W = mult4_pkg::W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  import mult4_pkg::*;

  state_e         state_q;
  logic           busy_q;
  logic           done_q;

  logic           start;
  logic           signed_mode;
  logic           load;
  logic           step;
  logic           last;
  logic [2*W-1:0] product;
  logic           unused_pins;

  assign start       = uio_in[START_BIT];
  assign signed_mode = uio_in[SIGNED_BIT];
  assign unused_pins = &{1'b0, uio_in[7:2]};

  // Strobes already include ena, so the datapath freezes with the FSM.
  assign load = ena & start & (state_q != RUN);
  assign step = ena & (state_q == RUN);

  mult4_datapath #(
    .W (W)
  ) u_datapath (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .step        (step),
    .signed_mode (signed_mode),
    .a_in        (ui_in[W-1:0]),
    .b_in        (ui_in[2*W-1:W]),
    .last        (last),
    .product     (product)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (ena) begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        RUN: begin
          if (last) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    uio_out           = 8'h00;
    uio_out[BUSY_BIT] = busy_q;
    uio_out[DONE_BIT] = done_q;
  end

  assign uo_out = product;
  assign uio_oe = UIO_OE_VAL;

endmodule : mult4_complete

`default_nettype wire

// File: tb/tb_mult4_complete.sv
// +--------------------------------------------------------------------+
// | tb_mult4_complete : directed vectors with queued expected products  |
// | Revision          : 1.0                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_mult4_complete;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  typedef struct {
    logic [7:0] prod;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  exp_t       popped;
  int         cyc;
  int         checks;
  int         errors;
  logic       done_prev;
  logic [7:0] prev_prod;

  mult4_complete dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every rising done pops one expected product and completion cycle.
  initial done_prev = 1'b0;
  always @(negedge clk) begin
    if (uio_out[3] && !done_prev) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no completion (cycle %0d)", cyc);
      end else begin
        popped = sb.pop_front();
        check("product", int'(uo_out), int'(popped.prod));
        check("done_cycle", cyc, popped.cyc);
        check("busy_at_done", int'(uio_out[2]), 0);
      end
    end
    done_prev <= uio_out[3];
  end

  // stall: cycles of ena=0 mid-RUN; repulse: start+new operands during RUN.
  task automatic run_op(input logic [7:0] ui, input logic sgn, input logic [7:0] exp,
                        input int stall, input bit repulse);
    @(negedge clk);
    ui_in  = ui;
    uio_in = {6'b0, sgn, 1'b1};
    sb.push_back('{exp, cyc + 5 + stall});
    @(negedge clk);
    uio_in = {6'b0, ~sgn, 1'b0};
    ui_in  = ~ui;
    check("busy_in_run", int'(uio_out[2]), 1);
    check("hold_prev", int'(uo_out), int'(prev_prod));
    @(negedge clk);
    if (repulse) begin
      uio_in[0] = 1'b1;
      ui_in     = 8'hFF;
      @(negedge clk);
      uio_in[0] = 1'b0;
    end
    if (stall > 0) begin
      ena = 1'b0;
      repeat (stall) @(negedge clk);
      ena = 1'b1;
    end
    repeat (4) @(negedge clk);
    check("done_hold", int'(uio_out[3]), 1);
    prev_prod = exp;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    prev_prod = 8'h00;
    rst       = 1'b1;
    ena       = 1'b1;
    ui_in     = 8'h00;
    uio_in    = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_uo_out", int'(uo_out), 8'h00);
    check("rst_uio_out", int'(uio_out), 8'h00);
    check("uio_oe", int'(uio_oe), 8'h0C);
    rst = 1'b0;

    run_op(8'h53, 1'b0, 8'h0F, 0, 1'b0);   // 3 x 5
    run_op(8'hFF, 1'b0, 8'hE1, 0, 1'b0);   // 15 x 15
    run_op(8'h90, 1'b0, 8'h00, 0, 1'b0);   // 0 x 9
    run_op(8'hD9, 1'b0, 8'h75, 0, 1'b0);   // 9 x 13
    run_op(8'h5D, 1'b1, 8'hF1, 0, 1'b0);   // -3 x 5
    run_op(8'h88, 1'b1, 8'h40, 0, 1'b0);   // -8 x -8
    run_op(8'h78, 1'b1, 8'hC8, 0, 1'b0);   // -8 x 7
    run_op(8'hD9, 1'b1, 8'h15, 0, 1'b0);   // -7 x -3
    run_op(8'h37, 1'b1, 8'h15, 0, 1'b0);   // 7 x 3
    run_op(8'h32, 1'b0, 8'h06, 0, 1'b1);   // 2 x 3, restart attempt ignored

    // Reset during the second RUN cycle aborts the operation.
    @(negedge clk);
    ui_in  = 8'h53;
    uio_in = 8'h01;
    sb.push_back('{8'h0F, cyc + 5});
    @(negedge clk);
    uio_in = 8'h00;
    check("busy_before_rst", int'(uio_out[2]), 1);
    @(negedge clk);
    rst = 1'b1;
    sb.delete(sb.size() - 1);
    @(negedge clk);
    rst = 1'b0;
    check("abort_uo_out", int'(uo_out), 8'h00);
    check("abort_busy", int'(uio_out[2]), 0);
    check("abort_done", int'(uio_out[3]), 0);
    prev_prod = 8'h00;
    repeat (5) @(negedge clk);

    run_op(8'h76, 1'b0, 8'h2A, 3, 1'b0);   // 6 x 7 with ena low 3 cycles
    run_op(8'h53, 1'b0, 8'h0F, 0, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_mult4_complete

`default_nettype wire

// File: doc/mult4_complete.md
# mult4_complete

Sequential 4×4 multiplier core with start/done handshake, unsigned and two's-complement modes, behind the standard Tiny Tapeout user pin set. It sits directly under the `tt_um_mult4_complete` project wrapper. The wrapper maps pins 1:1 and derives `rst` from the harness `rst_n`. The core multiplies two 4-bit operands from `ui_in` by shift-and-add over four cycles. It presents the 8-bit product on `uo_out`.

## Interface
- `W`, default 4: operand width; product width is `2*W`.
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `ena` input 1: design enable; when low, all registers hold and `start` is ignored.
- `ui_in` input 8: `[3:0]` operand A, `[7:4]` operand B.
- `uio_in` input 8: `[0]` start, `[1]` signed mode (1 = two's complement); `[7:2]` unused.
- `uo_out` output 8: product register.
- `uio_out` output 8: `[2]` busy, `[3]` done; all other bits 0.
- `uio_oe` output 8: constant `8'b0000_1100`.

## Operation
- FSM states are IDLE, RUN and DONE. Reset enters IDLE.
- **IDLE/DONE, `ena`=1 and start=1:**
  - Latch A, B and the signed flag.
  - In signed mode, store |A| and |B| plus `neg` = sign(A) XOR sign(B).
  - Clear the accumulator and set count=0. Go to RUN.
- **RUN, each enabled edge:**
  - If multiplier bit[count]=1, add (multiplicand << count) to the 8-bit accumulator.
  - Increment count.
  - After the edge that processes count=3, write the product to `uo_out` and go to DONE. The product is the accumulator, or its two's-complement negation when `neg`=1.
- **DONE:** hold the product and keep done=1 until the next start or reset. A start in DONE behaves exactly as a start in IDLE.
- A start while in RUN is ignored; operand changes during RUN have no effect.
- Arithmetic:
  - Unsigned range is 0..225.
  - Signed range is −56..64. Example: −8×−8 = 0x40 (fits in 8 bits). The result is the 8-bit two's complement of the true product.
  - |−8| = 8 requires a 4-bit unsigned magnitude path, so magnitudes are held unsigned.
- busy=1 exactly in RUN; done=1 exactly in DONE.

## Timing
- Reset values: `uo_out`=0x00, busy=0, done=0, state IDLE, accumulator 0. `uio_oe` is constant.
- Reset has priority over everything, including mid-RUN. It aborts the operation and clears `uo_out`.
- Latency: start is sampled at edge k. busy=1 after edge k. After edge k+4, done=1, busy=0 and `uo_out` is valid.
- `uo_out` keeps the previous product throughout RUN; it updates only on the completing edge.
- `ena`=0 freezes state, count, accumulator and outputs. Resuming continues where the operation left off.
- Throughput: one product per 5 cycles. Back-to-back is allowed by holding start high.

## Structure
- Package `mult4_pkg`:
  - state enum (IDLE, RUN, DONE);
  - `W`=4;
  - pin index constants (START_BIT=0, SIGNED_BIT=1, BUSY_BIT=2, DONE_BIT=3);
  - `UIO_OE_VAL`=`8'h0C`.
- Sub-module `mult4_datapath`:
  - holds the magnitude/sign conversion, shift-add accumulator and final negation;
  - is driven by `load` and `step` strobes from the top-level FSM;
  - returns the `last` flag when count=3.

## Test plan
- Unsigned 3×5: ui_in=0x53, start 1 cycle. busy for 4 cycles, then done=1 and `uo_out`=0x0F (15) after edge k+4.
- Unsigned 15×15 (ui_in=0xFF) → 0xE1. Next, 0×9 (ui_in=0x90) → 0x00 with done re-asserted.
- Signed mode: −3×5 (ui_in=0x5D) → 0xF1. −8×−8 (0x88) → 0x40. −8×7 (0x78) → 0xC8.
- Start pulsed again and ui_in changed during RUN: result is unchanged from the first operands, and completion occurs at the original cycle.
- Reset asserted at the 2nd RUN cycle: next edge gives busy=0, done=0, `uo_out`=0x00, state IDLE. A new start then completes normally.
- `ena` low for 3 cycles mid-RUN: done is delayed by exactly 3 cycles, and the product is still correct (e.g. 6×7 → 0x2A).
